motor_speed_ramp: RTL and testbench

//   Upstream of motor: turns the tracker's 3-bit steering mode into left/right
//   10-bit duty words driving motor.modulation_left/right. Debounces the mode,

---
 rtl/motor_speed_ramp.sv | 156 +++++++++++++++
 tb/tb_motor_speed_ramp.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/motor_speed_ramp.sv
// Debounces the 3-bit steering mode, maps it to per-wheel target duties and
// slew-limits the left/right duty words toward them; stop drops duty at once.
module motor_speed_ramp #(
    parameter int TICK_DIV     = 100000,
    parameter int STEP         = 16,
    parameter int MODE_STABLE  = 4,
    parameter int MIN_RUN      = 512,
    parameter int SPD_STRAIGHT = 1023,
    parameter int SPD_TURN_IN  = 768,
    parameter int SPD_SHARP_IN = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] mode,
    output logic [2:0] accepted_mode,
    output logic [9:0] modulation_left,
    output logic [9:0] modulation_right,
    output logic       settled
);

    localparam int TW    = $clog2(TICK_DIV + 1);
    localparam int CNT_W = $clog2(MODE_STABLE + 1);

    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0]    TICK_ONE  = TW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MODE_STABLE);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [10:0]      MIN_W     = 11'(MIN_RUN);
    localparam logic [10:0]      STEP_W    = 11'(STEP);
    localparam logic [9:0]       SPD_ST    = 10'(SPD_STRAIGHT);
    localparam logic [9:0]       SPD_TI    = 10'(SPD_TURN_IN);
    localparam logic [9:0]       SPD_SI    = 10'(SPD_SHARP_IN);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_HOLD = 2'd1,
        ST_RAMP = 2'd2
    } state_t;

    // Per-wheel targets packed as {left, right}; unused codes mean stop.
    function automatic logic [19:0] targets(input logic [2:0] m);
        logic [19:0] t;
        case (m)
            3'b000:  t = {SPD_TI, SPD_ST};
            3'b001:  t = {SPD_ST, SPD_TI};
            3'b010:  t = {SPD_ST, SPD_ST};
            3'b100:  t = {SPD_SI, SPD_ST};
            3'b101:  t = {SPD_ST, SPD_SI};
            default: t = 20'd0;
        endcase
        return t;
    endfunction

    // Differences are compared against STEP before adding/subtracting so the
    // 11-bit arithmetic can neither pass 1023 nor wrap below zero.
    function automatic logic [9:0] ramp_step(input logic [9:0] cur,
                                             input logic [9:0] tgt,
                                             input logic       tick);
        logic [10:0] c;
        logic [10:0] t;
        logic [10:0] r;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (t == 11'd0) begin
            r = 11'd0;
        end else if (!tick) begin
            r = c;
        end else if (c < MIN_W) begin
            r = MIN_W;
        end else if (c < t) begin
            r = ((t - c) > STEP_W) ? (c + STEP_W) : t;
        end else if (c > t) begin
            r = ((c - t) > STEP_W) ? (c - STEP_W) : t;
        end else begin
            r = c;
        end
        return r[9:0];
    endfunction

    logic [TW-1:0]    tick_q,  tick_d;
    logic [2:0]       cand_q,  cand_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       acc_q,   acc_d;
    logic [9:0]       left_q,  left_d;
    logic [9:0]       right_q, right_d;
    state_t           state_q, state_d;
    logic             settled_q;
    logic             tick_s;
    logic [9:0]       tgt_l_s, tgt_r_s;
    logic [9:0]       ntgt_l_s, ntgt_r_s;

    // Next-state logic: tick divider, mode debounce, ramp and settle state.
    always_comb begin
        tick_s = (tick_q == TICK_LAST);
        tick_d = tick_s ? '0 : (tick_q + TICK_ONE);

        if (mode == cand_q) begin
            cand_d = cand_q;
            cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
        end else begin
            cand_d = mode;
            cnt_d  = CNT_ONE;
        end

        if (cnt_d == CNT_MAX) begin
            acc_d = cand_d;
        end else begin
            acc_d = acc_q;
        end

        // Ramping uses the pre-edge accepted mode; the state looks ahead.
        {tgt_l_s, tgt_r_s}   = targets(acc_q);
        left_d               = ramp_step(left_q,  tgt_l_s, tick_s);
        right_d              = ramp_step(right_q, tgt_r_s, tick_s);
        {ntgt_l_s, ntgt_r_s} = targets(acc_d);

        if ((left_d == 10'd0) && (right_d == 10'd0) &&
            (ntgt_l_s == 10'd0) && (ntgt_r_s == 10'd0)) begin
            state_d = ST_STOP;
        end else if ((left_d == ntgt_l_s) && (right_d == ntgt_r_s) &&
                     (ntgt_l_s != 10'd0)) begin
            state_d = ST_HOLD;
        end else begin
            state_d = ST_RAMP;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q    <= '0;
            cand_q    <= 3'b011;
            cnt_q     <= '0;
            acc_q     <= 3'b011;
            left_q    <= 10'd0;
            right_q   <= 10'd0;
            state_q   <= ST_STOP;
            settled_q <= 1'b1;
        end else begin
            tick_q    <= tick_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            left_q    <= left_d;
            right_q   <= right_d;
            state_q   <= state_d;
            settled_q <= (state_d != ST_RAMP);
        end
    end

    assign accepted_mode    = acc_q;
    assign modulation_left  = left_q;
    assign modulation_right = right_q;
    assign settled          = settled_q;

endmodule

// File: tb/tb_motor_speed_ramp.sv
// Directed bench for motor_speed_ramp with TICK_DIV=4, STEP=128, MODE_STABLE=3.
module tb_motor_speed_ramp;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] mode;
    logic [2:0] accepted_mode;
    logic [9:0] modulation_left;
    logic [9:0] modulation_right;
    logic       settled;

    int checks = 0;
    int errors = 0;

    motor_speed_ramp #(
        .TICK_DIV    (4),
        .STEP        (128),
        .MODE_STABLE (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mode             (mode),
        .accepted_mode    (accepted_mode),
        .modulation_left  (modulation_left),
        .modulation_right (modulation_right),
        .settled          (settled)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] l, input logic [15:0] r,
                             input logic [15:0] acc, input logic [15:0] s);
        chk({tag, "_left"},    {6'd0, modulation_left},  l);
        chk({tag, "_right"},   {6'd0, modulation_right}, r);
        chk({tag, "_acc"},     {13'd0, accepted_mode},   acc);
        chk({tag, "_settled"}, {15'd0, settled},         s);
    endtask

    // Advance until either duty word moves (bounded), then check both.
    task automatic wait_change(input string tag, input logic [15:0] exp_l, input logic [15:0] exp_r);
        logic [9:0] pl;
        logic [9:0] pr;
        int n;
        pl = modulation_left;
        pr = modulation_right;
        n  = 0;
        do begin
            step();
            n++;
        end while (modulation_left == pl && modulation_right == pr && n < 12);
        chk({tag, "_left"},  {6'd0, modulation_left},  exp_l);
        chk({tag, "_right"}, {6'd0, modulation_right}, exp_r);
    endtask

    initial begin
        rst  = 1'b1;
        mode = 3'b010;
        step();
        step();
        check_all("reset", 16'd0, 16'd0, 16'd3, 16'd1);

        rst = 1'b0;
        step();
        chk("deb1_acc", {13'd0, accepted_mode}, 16'd3);
        step();
        chk("deb2_acc", {13'd0, accepted_mode}, 16'd3);
        step();
        check_all("accept", 16'd0, 16'd0, 16'd2, 16'd0);

        wait_change("up512", 16'd512, 16'd512);
        chk("up512_settled", {15'd0, settled}, 16'd0);
        wait_change("up640", 16'd640, 16'd640);
        wait_change("up768", 16'd768, 16'd768);
        wait_change("up896", 16'd896, 16'd896);
        chk("up896_settled", {15'd0, settled}, 16'd0);
        wait_change("up1023", 16'd1023, 16'd1023);
        chk("up1023_settled", {15'd0, settled}, 16'd1);

        mode = 3'b000;
        step();
        step();
        mode = 3'b010;
        for (int i = 0; i < 8; i++) begin
            step();
            check_all("glitch", 16'd1023, 16'd1023, 16'd2, 16'd1);
        end

        mode = 3'b100;
        wait_change("stl895", 16'd895, 16'd1023);
        chk("stl895_acc", {13'd0, accepted_mode}, 16'd4);
        chk("stl895_settled", {15'd0, settled}, 16'd0);
        wait_change("stl767", 16'd767, 16'd1023);
        wait_change("stl639", 16'd639, 16'd1023);
        wait_change("stl512", 16'd512, 16'd1023);
        chk("stl512_settled", {15'd0, settled}, 16'd1);

        mode = 3'b010;
        wait_change("resume640", 16'd640, 16'd1023);
        rst = 1'b1;
        step();
        check_all("midrst", 16'd0, 16'd0, 16'd3, 16'd1);
        rst = 1'b0;
        step();
        check_all("postrst1", 16'd0, 16'd0, 16'd3, 16'd1);
        step();
        check_all("postrst2", 16'd0, 16'd0, 16'd3, 16'd1);
        step();
        check_all("reaccept", 16'd0, 16'd0, 16'd2, 16'd0);
        wait_change("re512", 16'd512, 16'd512);
        wait_change("re640", 16'd640, 16'd640);

        // Acceptance lands on a tick edge (old target still ramps), stop one edge later.
        step();
        mode = 3'b011;
        step();
        step();
        step();
        check_all("stop_acc", 16'd768, 16'd768, 16'd3, 16'd0);
        step();
        check_all("stop", 16'd0, 16'd0, 16'd3, 16'd1);

        mode = 3'b010;
        wait_change("again512", 16'd512, 16'd512);
        wait_change("again640", 16'd640, 16'd640);
        step();
        mode = 3'b111;
        step();
        step();
        step();
        check_all("stop7_acc", 16'd768, 16'd768, 16'd7, 16'd0);
        step();
        check_all("stop7", 16'd0, 16'd0, 16'd7, 16'd1);
        step();
        check_all("stop7_hold", 16'd0, 16'd0, 16'd7, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
